// File: rtl/quad_rasterizer.sv
// quad_rasterizer
//   Rasterizes one screen-space quad as two triangles, A = (v0,v1,v2) then
//   B = (v0,v2,v3). Each triangle's clipped bounding box is scanned row-major,
//   one candidate pixel per advancing cycle. Edge functions are updated
//   incrementally, and covered pixels go out on a valid/ready stream.
//
// Ports
//   Clk          in   clock, all logic on posedge
//   Reset        in   synchronous, active-high
//   in_vertices  in   [i][0] = x, [i][1] = y, unsigned 10-bit, i = 0..3
//   in_tuser     in   16-bit tag copied to every pixel of the quad
//   in_valid     in   quad present
//   in_ready     out  high only while idle and not in reset
//   pix_x/pix_y  out  pixel coordinates
//   pix_tuser    out  tag of the owning quad
//   pix_valid    out  pixel held on the output register
//   pix_ready    in   downstream accepts the pixel
//   quad_done    out  one-cycle pulse once the quad has been fully scanned

module quad_rasterizer #(
    parameter int unsigned SCREEN_W = 640,
    parameter int unsigned SCREEN_H = 480,
    parameter int unsigned EW       = 24
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [3:0][1:0][9:0] in_vertices,
    input  logic [15:0]          in_tuser,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [9:0]           pix_x,
    output logic [9:0]           pix_y,
    output logic [15:0]          pix_tuser,
    output logic                 pix_valid,
    input  logic                 pix_ready,
    output logic                 quad_done
);

    typedef enum logic [2:0] {StIdle, StSetup, StInit, StScan, StDone} state_t;

    localparam logic [9:0] XLim = 10'(SCREEN_W - 1);
    localparam logic [9:0] YLim = 10'(SCREEN_H - 1);

    state_t               r_state;
    logic                 r_tri;          // 0: triangle A, 1: triangle B
    logic [3:0][1:0][9:0] r_vert;
    logic [15:0]          r_tuser;
    logic [9:0]           r_xmin, r_xmax, r_ymin, r_ymax;
    logic [9:0]           r_x, r_y;
    logic [9:0]           r_ax [3];
    logic [9:0]           r_ay [3];
    logic signed [10:0]   r_dx [3];
    logic signed [10:0]   r_dy [3];
    logic signed [EW-1:0] r_e    [3];
    logic signed [EW-1:0] r_erow [3];
    logic [9:0]           r_pix_x, r_pix_y;
    logic [15:0]          r_pix_tuser;
    logic                 r_pix_valid;
    logic                 r_quad_done;

    logic [9:0]           w_px [3];
    logic [9:0]           w_py [3];
    logic signed [10:0]   w_dx [3];
    logic signed [10:0]   w_dy [3];
    logic signed [EW-1:0] w_area;
    logic [9:0]           w_xmin, w_xmax, w_ymin, w_ymax;
    logic signed [EW-1:0] w_einit [3];
    logic signed [EW-1:0] w_sdx [3];
    logic signed [EW-1:0] w_sdy [3];
    logic                 w_all_ge, w_all_le, w_covered;
    logic                 w_adv, w_eol, w_last;

    function automatic logic [9:0] min3(input logic [9:0] a, input logic [9:0] b,
                                        input logic [9:0] c);
        logic [9:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic [9:0] max3(input logic [9:0] a, input logic [9:0] b,
                                        input logic [9:0] c);
        logic [9:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    function automatic logic [9:0] clamp(input logic [9:0] v, input logic [9:0] lim);
        return (v > lim) ? lim : v;
    endfunction

    function automatic logic signed [EW-1:0] sext(input logic signed [10:0] v);
        return {{(EW-11){v[10]}}, v};
    endfunction

    // E_ab(p) = (px-ax)*dy - (py-ay)*dx, exact in EW bits
    function automatic logic signed [EW-1:0] edge_fn(
        input logic [9:0]         px,
        input logic [9:0]         py,
        input logic [9:0]         ax,
        input logic [9:0]         ay,
        input logic signed [10:0] dx,
        input logic signed [10:0] dy
    );
        logic signed [EW-1:0] rel_x, rel_y;
        rel_x = EW'(px) - EW'(ax);
        rel_y = EW'(py) - EW'(ay);
        return rel_x * sext(dy) - rel_y * sext(dx);
    endfunction

    // Current triangle's corners and its three edges (p0->p1, p1->p2, p2->p0).
    // In B, edge 0 is the shared v0->v2 diagonal.
    always_comb begin
        w_px[0] = r_vert[0][0];
        w_py[0] = r_vert[0][1];
        w_px[1] = r_tri ? r_vert[2][0] : r_vert[1][0];
        w_py[1] = r_tri ? r_vert[2][1] : r_vert[1][1];
        w_px[2] = r_tri ? r_vert[3][0] : r_vert[2][0];
        w_py[2] = r_tri ? r_vert[3][1] : r_vert[2][1];
        for (int i = 0; i < 3; i++) begin
            w_dx[i] = $signed({1'b0, w_px[(i == 2) ? 0 : i + 1]}) - $signed({1'b0, w_px[i]});
            w_dy[i] = $signed({1'b0, w_py[(i == 2) ? 0 : i + 1]}) - $signed({1'b0, w_py[i]});
        end
        // Twice the signed area; zero means the triangle covers nothing
        w_area = sext(w_dy[0]) * sext(w_dx[2]) - sext(w_dx[0]) * sext(w_dy[2]);
        w_xmin = clamp(min3(w_px[0], w_px[1], w_px[2]), XLim);
        w_xmax = clamp(max3(w_px[0], w_px[1], w_px[2]), XLim);
        w_ymin = clamp(min3(w_py[0], w_py[1], w_py[2]), YLim);
        w_ymax = clamp(max3(w_py[0], w_py[1], w_py[2]), YLim);
    end

    always_comb begin
        w_all_ge = 1'b1;
        w_all_le = 1'b1;
        for (int i = 0; i < 3; i++) begin
            w_sdx[i]   = sext(r_dx[i]);
            w_sdy[i]   = sext(r_dy[i]);
            w_einit[i] = edge_fn(r_xmin, r_ymin, r_ax[i], r_ay[i], r_dx[i], r_dy[i]);
            if (r_e[i][EW-1]) begin
                w_all_ge = 1'b0;
            end
            if (!r_e[i][EW-1] && (r_e[i] != '0)) begin
                w_all_le = 1'b0;
            end
        end
        // Pixels on the diagonal belong to A only
        w_covered = (w_all_ge || w_all_le) && !(r_tri && (r_e[0] == '0));
        w_adv     = !r_pix_valid || pix_ready;
        w_eol     = (r_x == r_xmax);
        w_last    = w_eol && (r_y == r_ymax);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state     <= StIdle;
            r_tri       <= 1'b0;
            r_pix_x     <= '0;
            r_pix_y     <= '0;
            r_pix_tuser <= '0;
            r_pix_valid <= 1'b0;
            r_quad_done <= 1'b0;
        end else begin
            r_quad_done <= 1'b0;
            // Retire a pixel taken downstream; SCAN may overwrite below
            if (r_pix_valid && pix_ready) begin
                r_pix_valid <= 1'b0;
            end
            unique case (r_state)
                StIdle: begin
                    if (in_valid) begin
                        r_vert  <= in_vertices;
                        r_tuser <= in_tuser;
                        r_tri   <= 1'b0;
                        r_state <= StSetup;
                    end
                end
                StSetup: begin
                    r_xmin <= w_xmin;
                    r_xmax <= w_xmax;
                    r_ymin <= w_ymin;
                    r_ymax <= w_ymax;
                    for (int i = 0; i < 3; i++) begin
                        r_ax[i] <= w_px[i];
                        r_ay[i] <= w_py[i];
                        r_dx[i] <= w_dx[i];
                        r_dy[i] <= w_dy[i];
                    end
                    if (w_area != '0) begin
                        r_state <= StInit;
                    end else if (!r_tri) begin
                        r_tri <= 1'b1;  // stay in SETUP for B
                    end else begin
                        r_state <= StDone;
                    end
                end
                StInit: begin
                    r_x <= r_xmin;
                    r_y <= r_ymin;
                    for (int i = 0; i < 3; i++) begin
                        r_e[i]    <= w_einit[i];
                        r_erow[i] <= w_einit[i];
                    end
                    r_state <= StScan;
                end
                StScan: begin
                    if (w_adv) begin
                        r_pix_valid <= w_covered;
                        if (w_covered) begin
                            r_pix_x     <= r_x;
                            r_pix_y     <= r_y;
                            r_pix_tuser <= r_tuser;
                        end
                        if (w_last) begin
                            if (!r_tri) begin
                                r_tri   <= 1'b1;
                                r_state <= StSetup;
                            end else begin
                                r_state <= StDone;
                            end
                        end else if (w_eol) begin
                            r_x <= r_xmin;
                            r_y <= r_y + 10'd1;
                            for (int i = 0; i < 3; i++) begin
                                r_erow[i] <= r_erow[i] - w_sdx[i];
                                r_e[i]    <= r_erow[i] - w_sdx[i];
                            end
                        end else begin
                            r_x <= r_x + 10'd1;
                            for (int i = 0; i < 3; i++) begin
                                r_e[i] <= r_e[i] + w_sdy[i];
                            end
                        end
                    end
                end
                StDone: begin
                    r_quad_done <= 1'b1;
                    r_state     <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign in_ready  = (r_state == StIdle) && !Reset;
    assign pix_x     = r_pix_x;
    assign pix_y     = r_pix_y;
    assign pix_tuser = r_pix_tuser;
    assign pix_valid = r_pix_valid;
    assign quad_done = r_quad_done;

endmodule
